// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the instruction-memory port, the control inputs and the IR
// handshake toward decode.
interface fetch_unit_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_instr;
   logic               stall;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_target;
   logic               ir_valid;
   logic [INSTR_W-1:0] ir_instr;
   logic [ADDR_W-1:0]  ir_pc;
   logic               ir_ready;
   logic               halted;

   // fetch unit side
   modport slave (
      output imem_addr, ir_valid, ir_instr, ir_pc, halted,
      input  imem_instr, stall, redirect_valid, redirect_target, ir_ready
   );

   // memory/control/decode side
   modport master (
      input  imem_addr, ir_valid, ir_instr, ir_pc, halted,
      output imem_instr, stall, redirect_valid, redirect_target, ir_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR with valid/ready toward decode, stall, redirect/flush
// and halt-on-word.
module fetch_unit #(
   parameter int                ADDR_W     = 16,
   parameter int                INSTR_W    = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC   = 16'h0000,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF
) (
   input logic         clk,
   input logic         rst_n,
   fetch_unit_if.slave bus
);

   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

   state_t             r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
   logic               r_ir_valid, w_ir_valid_nxt;
   logic [INSTR_W-1:0] r_ir_instr, w_ir_instr_nxt;
   logic [ADDR_W-1:0]  r_ir_pc, w_ir_pc_nxt;
   logic               r_halted;

   logic w_fetch_en;
   logic w_drain;
   logic w_is_halt;

   assign w_fetch_en = (r_state == RUN) && !bus.stall && !bus.redirect_valid &&
                       (!r_ir_valid || bus.ir_ready);
   assign w_drain    = r_ir_valid && bus.ir_ready;
   assign w_is_halt  = (bus.imem_instr == HALT_INSTR);

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_ir_valid_nxt = r_ir_valid;
      w_ir_instr_nxt = r_ir_instr;
      w_ir_pc_nxt    = r_ir_pc;
      // redirect wins over everything, flushing IR even if decode is taking it
      if (bus.redirect_valid) begin
         w_pc_nxt       = bus.redirect_target;
         w_ir_valid_nxt = 1'b0;
         w_state_nxt    = RUN;
      end else begin
         unique case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
               if (w_fetch_en) begin
                  w_ir_instr_nxt = bus.imem_instr;
                  w_ir_pc_nxt    = r_pc;
                  w_ir_valid_nxt = 1'b1;
                  if (w_is_halt) w_state_nxt = HALT;
                  else           w_pc_nxt    = r_pc + ADDR_W'(1);
               end else if (w_drain) begin
                  w_ir_valid_nxt = 1'b0;
               end
            end
            HALT: begin
               if (w_drain) w_ir_valid_nxt = 1'b0;
            end
            default: w_state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= BOOT;
         r_pc       <= RESET_PC;
         r_ir_valid <= 1'b0;
         r_ir_instr <= '0;
         r_ir_pc    <= '0;
         r_halted   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_ir_valid <= w_ir_valid_nxt;
         r_ir_instr <= w_ir_instr_nxt;
         r_ir_pc    <= w_ir_pc_nxt;
         r_halted   <= (w_state_nxt == HALT);
      end
   end

   assign bus.imem_addr = r_pc;
   assign bus.ir_valid  = r_ir_valid;
   assign bus.ir_instr  = r_ir_instr;
   assign bus.ir_pc     = r_ir_pc;
   assign bus.halted    = r_halted;

endmodule
